// File: rtl/wishbone_gpio_slave_pkg.sv
// Shared definitions for the Wishbone GPIO slave.
// Contents:
//   - word-offset constants for the eight-entry register map
//   - FSM state encoding for the bus handshake
//   - lane_mask(): expands the byte-lane enables into a 32-bit bit mask
package wishbone_gpio_pkg;

  localparam logic [2:0] REG_OUT    = 3'd0;
  localparam logic [2:0] REG_DIR    = 3'd1;
  localparam logic [2:0] REG_IN     = 3'd2;
  localparam logic [2:0] REG_SET    = 3'd3;
  localparam logic [2:0] REG_CLR    = 3'd4;
  localparam logic [2:0] REG_TGL    = 3'd5;
  localparam logic [2:0] REG_EDGE   = 3'd6;
  localparam logic [2:0] REG_IRQ_EN = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } wb_state_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{sel[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wishbone_gpio_slave_input_sync.sv
// Input path for the GPIO slave.
// Each pin passes through a STAGES-deep flip-flop synchroniser. The
// synchronised value is exported as o_in, and its previous-cycle copy is
// kept to detect rising edges on input pins (i_dir = 0). Rising edges
// stay masked until an arm counter has run STAGES+1 cycles after reset
// release. This prevents a pin that was already high during reset from
// being reported as a new edge while the chain fills.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_pins       : raw asynchronous pin inputs
//   i_dir        : direction register (1 = output, no edge detection)
//   o_in         : synchronised pin values
//   o_rise       : single-cycle rising-edge vector
module gpio_input_sync #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_pins,
  input  logic [WIDTH-1:0] i_dir,
  output logic [WIDTH-1:0] o_in,
  output logic [WIDTH-1:0] o_rise
);

  localparam logic [2:0] ARM_DONE = 3'(STAGES + 1);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]             r_prev;
  logic [2:0]                   r_arm;
  logic                         w_armed;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= '0;
      r_arm  <= '0;
    end else begin
      r_sync[0] <= i_pins;
      for (int unsigned k = 1; k < STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_prev <= r_sync[STAGES-1];
      if (!w_armed) begin
        r_arm <= r_arm + 3'd1;
      end
    end
  end

  assign o_in    = r_sync[STAGES-1];
  assign w_armed = (r_arm == ARM_DONE);
  assign o_rise  = w_armed ? (o_in & ~r_prev & ~i_dir) : '0;

endmodule

// File: rtl/wishbone_gpio_slave.sv
// Wishbone classic GPIO slave.
// Provides these registers:
//   - an output register with atomic set, clear and toggle aliases
//   - a per-pin direction register
//   - synchronised input sampling
//   - sticky rising-edge capture, cleared by writing 1
//   - a maskable, registered interrupt
// Each access takes two cycles: the request is sampled in IDLE, where
// writes commit and read data is registered. ack_o is then high for
// exactly one cycle (ACK).
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   addr_i[4:2]           : word offset (other address bits ignored)
//   we_i, sel_i, data_i   : write enable, byte lanes, write data
//   cyc_i, stb_i          : bus cycle / strobe
//   data_o, ack_o         : read data (0 outside ACK), acknowledge
//   gpio_i                : asynchronous pin inputs
//   gpio_o, gpio_oe_o     : pin outputs (optionally inverted), output enables
//   irq_o                 : interrupt, |(EDGE & IRQ_EN) registered
module wishbone_gpio_slave
  import wishbone_gpio_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH  = 32,
  parameter bit          ACTIVE_LOW  = 1'b0,
  parameter logic [31:0] OUT_RESET   = 32'h0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            sel_i,
  input  logic [31:0]           data_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  output logic [31:0]           data_o,
  output logic                  ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);

  wb_state_t r_state, w_state_next;
  logic      w_access;
  logic      w_wr;

  logic [2:0]  w_off;
  logic [31:0] w_lmask;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic [31:0] r_rdata;
  logic        r_irq;
  logic        w_unused;

  logic [GPIO_WIDTH-1:0] r_out, r_dir, r_edge, r_irq_en;
  logic [GPIO_WIDTH-1:0] w_out_next, w_dir_next, w_irq_en_next, w_edge_next;
  logic [GPIO_WIDTH-1:0] w_lm, w_wd, w_w1c;
  logic [GPIO_WIDTH-1:0] w_in, w_rise;

  gpio_input_sync #(
    .WIDTH  (GPIO_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_input_sync (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_pins (gpio_i),
    .i_dir  (r_dir),
    .o_in   (w_in),
    .o_rise (w_rise)
  );

  assign w_off   = addr_i[4:2];
  assign w_lmask = lane_mask(sel_i);
  // Lanes that are not selected become zero data. For OUT, DIR and IRQ_EN
  // they also keep the old register bits through w_lm.
  assign w_wdata = data_i & w_lmask;
  assign w_lm    = w_lmask[GPIO_WIDTH-1:0];
  assign w_wd    = w_wdata[GPIO_WIDTH-1:0];
  assign w_wr    = w_access & we_i;

  // Ignored address bits and bits above GPIO_WIDTH.
  assign w_unused = ^{addr_i[31:5], addr_i[1:0], w_lmask, w_wdata};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_access     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cyc_i && stb_i) begin
          w_access     = 1'b1;
          w_state_next = ACK;
        end
      end
      ACK: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_out_next    = r_out;
    w_dir_next    = r_dir;
    w_irq_en_next = r_irq_en;
    w_w1c         = '0;
    if (w_wr) begin
      case (w_off)
        REG_OUT:    w_out_next    = (r_out & ~w_lm) | w_wd;
        REG_DIR:    w_dir_next    = (r_dir & ~w_lm) | w_wd;
        REG_SET:    w_out_next    = r_out | w_wd;
        REG_CLR:    w_out_next    = r_out & ~w_wd;
        REG_TGL:    w_out_next    = r_out ^ w_wd;
        REG_EDGE:   w_w1c         = w_wd;
        REG_IRQ_EN: w_irq_en_next = (r_irq_en & ~w_lm) | w_wd;
        default:    ;
      endcase
    end
    // A new edge takes priority over a clear that hits the same bit.
    w_edge_next = (r_edge & ~w_w1c) | w_rise;
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      REG_OUT:    w_rdata = 32'(r_out);
      REG_DIR:    w_rdata = 32'(r_dir);
      REG_IN:     w_rdata = 32'(w_in);
      REG_EDGE:   w_rdata = 32'(r_edge);
      REG_IRQ_EN: w_rdata = 32'(r_irq_en);
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out    <= OUT_RESET[GPIO_WIDTH-1:0];
      r_dir    <= '0;
      r_edge   <= '0;
      r_irq_en <= '0;
      r_irq    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_out    <= w_out_next;
      r_dir    <= w_dir_next;
      r_edge   <= w_edge_next;
      r_irq_en <= w_irq_en_next;
      r_irq    <= |(r_edge & r_irq_en);
      r_rdata  <= (w_access && !we_i) ? w_rdata : '0;
    end
  end

  assign ack_o     = (r_state == ACK);
  assign data_o    = r_rdata;
  assign gpio_o    = r_out ^ {GPIO_WIDTH{ACTIVE_LOW}};
  assign gpio_oe_o = r_dir;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_wishbone_gpio_slave.sv
module tb_wishbone_gpio_slave;
  import wishbone_gpio_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic        stb;
  logic        cyc32, cyc8;

  logic [31:0] data32, data8;
  logic        ack32, ack8;
  logic [31:0] gpi32, gpo32, gpoe32;
  logic [7:0]  gpi8, gpo8, gpoe8;
  logic        irq32, irq8;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wishbone_gpio_slave #(
    .GPIO_WIDTH  (32),
    .ACTIVE_LOW  (1'b0),
    .OUT_RESET   (32'h0000_00A5),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i (clk), .rst_i (rst), .addr_i (addr), .we_i (we), .sel_i (sel),
    .data_i (wdat), .cyc_i (cyc32), .stb_i (stb), .data_o (data32),
    .ack_o (ack32), .gpio_i (gpi32), .gpio_o (gpo32), .gpio_oe_o (gpoe32),
    .irq_o (irq32)
  );

  wishbone_gpio_slave #(
    .GPIO_WIDTH  (8),
    .ACTIVE_LOW  (1'b1),
    .OUT_RESET   (32'h0),
    .SYNC_STAGES (2)
  ) dut8 (
    .clk_i (clk), .rst_i (rst), .addr_i (addr), .we_i (we), .sel_i (sel),
    .data_i (wdat), .cyc_i (cyc8), .stb_i (stb), .data_o (data8),
    .ack_o (ack8), .gpio_i (gpi8), .gpio_o (gpo8), .gpio_oe_o (gpoe8),
    .irq_o (irq8)
  );

  typedef struct {
    logic        we;
    logic [2:0]  off;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a negedge. Drives one access. The ack must appear at the
  // next negedge. For a read, the expected value is popped from exp_q.
  task automatic wb(input bit t8, input bit w, input logic [31:0] a,
                    input logic [3:0] s, input logic [31:0] d);
    bit got;
    int lat;
    logic [31:0] e;
    addr = a; we = w; sel = s; wdat = d; stb = 1'b1;
    if (t8) cyc8 = 1'b1; else cyc32 = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (t8 ? ack8 : ack32) begin
        got = 1'b1;
        lat = k;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: got no ack expected ack within 4 cycles");
      if (!w && exp_q.size() > 0) e = exp_q.pop_front();
    end else begin
      chk("ack_latency", 32'(lat), 32'd0);
      if (!w) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty: got %h expected queued value", t8 ? data8 : data32);
        end else begin
          e = exp_q.pop_front();
          chk("read_data", t8 ? data8 : data32, e);
        end
      end else begin
        chk("write_ack_data_zero", t8 ? data8 : data32, 32'h0);
      end
    end
    stb = 1'b0; cyc32 = 1'b0; cyc8 = 1'b0;
    @(negedge clk);
    chk("ack_single_cycle", {31'h0, (t8 ? ack8 : ack32)}, 32'h0);
    chk("data_idle_zero", t8 ? data8 : data32, 32'h0);
  endtask

  function automatic logic [31:0] ad(input logic [2:0] off);
    return {27'h0, off, 2'b00};
  endfunction

  initial begin
    vecs[0]  = '{1'b0, REG_EDGE,   4'hF, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, REG_IN,     4'hF, 32'h0,         32'h0000_0008};
    vecs[2]  = '{1'b0, REG_OUT,    4'hF, 32'h0,         32'h0000_00A5};
    vecs[3]  = '{1'b1, REG_OUT,    4'hF, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, REG_OUT,    4'h5, 32'h1234_5678, 32'h0};
    vecs[5]  = '{1'b0, REG_OUT,    4'hF, 32'h0,         32'h0034_0078};
    vecs[6]  = '{1'b1, REG_SET,    4'hF, 32'h0000_FF00, 32'h0};
    vecs[7]  = '{1'b0, REG_OUT,    4'hF, 32'h0,         32'h0034_FF78};
    vecs[8]  = '{1'b1, REG_CLR,    4'hF, 32'h0030_0000, 32'h0};
    vecs[9]  = '{1'b0, REG_OUT,    4'hF, 32'h0,         32'h0004_FF78};
    vecs[10] = '{1'b1, REG_TGL,    4'hF, 32'h0000_0001, 32'h0};
    vecs[11] = '{1'b0, REG_OUT,    4'hF, 32'h0,         32'h0004_FF79};
    vecs[12] = '{1'b1, REG_SET,    4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[13] = '{1'b0, REG_OUT,    4'hF, 32'h0,         32'h0004_FF79};
    vecs[14] = '{1'b0, REG_SET,    4'hF, 32'h0,         32'h0};
    vecs[15] = '{1'b0, REG_TGL,    4'hF, 32'h0,         32'h0};
    vecs[16] = '{1'b1, REG_DIR,    4'h1, 32'h0000_A5F0, 32'h0};
    vecs[17] = '{1'b0, REG_DIR,    4'hF, 32'h0,         32'h0000_00F0};
    vecs[18] = '{1'b1, REG_IRQ_EN, 4'hF, 32'h0000_0001, 32'h0};
    vecs[19] = '{1'b0, REG_IRQ_EN, 4'hF, 32'h0,         32'h0000_0001};
    vecs[20] = '{1'b1, REG_IN,     4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[21] = '{1'b0, REG_IN,     4'hF, 32'h0,         32'h0000_0008};

    rst = 1'b1; addr = '0; we = 1'b0; sel = '0; wdat = '0; stb = 1'b0;
    cyc32 = 1'b0; cyc8 = 1'b0;
    gpi32 = 32'h0000_0008;   // bit 3 held high through reset
    gpi8 = '0;
    wait_neg(3);
    rst = 1'b0;

    // Reset state
    chk("rst_ack", {31'h0, ack32}, 32'h0);
    chk("rst_data", data32, 32'h0);
    chk("rst_irq", {31'h0, irq32}, 32'h0);
    chk("rst_gpio_oe", gpoe32, 32'h0);
    chk("rst_gpio_o", gpo32, 32'h0000_00A5);
    chk("rst_gpio_o_w8_inv", {24'h0, gpo8}, 32'h0000_00FF);
    chk("rst_gpio_oe_w8", {24'h0, gpoe8}, 32'h0);
    wait_neg(6);

    // Register-map vectors
    for (int i = 0; i < 22; i++) begin
      if (!vecs[i].we) exp_q.push_back(vecs[i].exp);
      wb(1'b0, vecs[i].we, ad(vecs[i].off), vecs[i].sel, vecs[i].data);
    end
    exp_q.push_back(32'h0004_FF79);
    wb(1'b0, 1'b0, 32'hFFFF_FFE3, 4'hF, 32'h0);   // aliases word 0
    chk("pins_out", gpo32, 32'h0004_FF79);
    chk("pins_oe", gpoe32, 32'h0000_00F0);

    // Rising edge on bit 0, input direction, IRQ_EN[0]=1
    gpi32[0] = 1'b1;
    wait_neg(3);
    chk("irq_before_latency", {31'h0, irq32}, 32'h0);
    @(negedge clk);
    chk("irq_after_edge", {31'h0, irq32}, 32'h1);
    gpi32[0] = 1'b0;
    exp_q.push_back(32'h1);
    wb(1'b0, 1'b0, ad(REG_EDGE), 4'hF, 32'h0);
    wb(1'b0, 1'b1, ad(REG_EDGE), 4'hF, 32'h1);
    chk("irq_after_w1c", {31'h0, irq32}, 32'h0);
    exp_q.push_back(32'h0);
    wb(1'b0, 1'b0, ad(REG_EDGE), 4'hF, 32'h0);

    // Same bit configured as output: no edge
    wb(1'b0, 1'b1, ad(REG_DIR), 4'hF, 32'h0000_00F1);
    gpi32[0] = 1'b1;
    wait_neg(5);
    chk("irq_dir_out", {31'h0, irq32}, 32'h0);
    exp_q.push_back(32'h0);
    wb(1'b0, 1'b0, ad(REG_EDGE), 4'hF, 32'h0);
    gpi32[0] = 1'b0;

    // Bit 2: capture, then a new edge coincident with its W1C
    gpi32[2] = 1'b1;
    wait_neg(4);
    exp_q.push_back(32'h4);
    wb(1'b0, 1'b0, ad(REG_EDGE), 4'hF, 32'h0);
    gpi32[2] = 1'b0;
    wait_neg(4);
    gpi32[2] = 1'b1;
    wait_neg(2);
    wb(1'b0, 1'b1, ad(REG_EDGE), 4'hF, 32'h4);
    exp_q.push_back(32'h4);
    wb(1'b0, 1'b0, ad(REG_EDGE), 4'hF, 32'h0);
    wb(1'b0, 1'b1, ad(REG_EDGE), 4'hF, 32'h4);
    exp_q.push_back(32'h0);
    wb(1'b0, 1'b0, ad(REG_EDGE), 4'hF, 32'h0);

    // Reset during ACK
    addr = ad(REG_OUT); we = 1'b1; sel = 4'hF; wdat = 32'h0000_0F0F;
    stb = 1'b1; cyc32 = 1'b1;
    @(negedge clk);
    chk("midack_ack_high", {31'h0, ack32}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("midack_ack_drop", {31'h0, ack32}, 32'h0);
    chk("midack_out_reset", gpo32, 32'h0000_00A5);
    chk("midack_dir_reset", gpoe32, 32'h0);
    stb = 1'b0; cyc32 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'h0000_00A5);
    wb(1'b0, 1'b0, ad(REG_OUT), 4'hF, 32'h0);
    exp_q.push_back(32'h0);
    wb(1'b0, 1'b0, ad(REG_DIR), 4'hF, 32'h0);

    // Back-to-back SET writes with strobe held
    addr = ad(REG_SET); we = 1'b1; sel = 4'hF; wdat = 32'h1;
    stb = 1'b1; cyc32 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("b2b_ack", {31'h0, ack32}, (k % 2 == 0) ? 32'h1 : 32'h0);
      if (k == 1) wdat = 32'h4;
      if (k == 3) wdat = 32'h10;
      if (k == 4) begin
        stb = 1'b0; cyc32 = 1'b0;
      end
    end
    exp_q.push_back(32'h0000_00B5);
    wb(1'b0, 1'b0, ad(REG_OUT), 4'hF, 32'h0);

    // 8-pin, active-low instance
    wb(1'b1, 1'b1, ad(REG_OUT), 4'hF, 32'hFFFF_FFFF);
    chk("w8_gpio_o_inv", {24'h0, gpo8}, 32'h0);
    exp_q.push_back(32'h0000_00FF);
    wb(1'b1, 1'b0, ad(REG_OUT), 4'hF, 32'h0);
    wb(1'b1, 1'b1, ad(REG_DIR), 4'hF, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_00FF);
    wb(1'b1, 1'b0, ad(REG_DIR), 4'hF, 32'h0);
    chk("w8_gpio_oe", {24'h0, gpoe8}, 32'h0000_00FF);
    chk("w8_irq", {31'h0, irq8}, 32'h0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
